// File: rtl/qspi_receiver.sv
`timescale 1ns/1ps
// qspi_receiver
// Target-side QSPI receiver. SPI_CLK, CE and DQ are oversampled in the CLK
// domain through identical synchroniser chains. Data on DQ[0] (single mode)
// or DQ[3:0] (quad mode) is shifted in MSB first on every SPI_CLK rising
// edge. Each completed word is offered through a one-word holding register
// with a valid/ready handshake.
//
// Optional build macro: QSPI_RX_TIMEOUT_EN
//   When defined, a frame that sees no SPI_CLK rising edge for G_TIMEOUT
//   CLK cycles is aborted with FRAME_ERR. When undefined, no idle counter
//   is built and G_TIMEOUT has no effect.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   SPI_CLK    serial clock (CPOL=0, sample on rising edge)
//   CE         chip enable, active low, frames the transfer
//   DQ[3:0]    data lanes (DQ[0] only in single mode)
//   QUAD_MODE  lane mode, captured when a frame starts
//   DATA_OUT   received word, stable while DO_VALID=1
//   DO_VALID   holding register full
//   DO_READY   consumer accepts the word when DO_VALID & DO_READY
//   RX_BUSY    frame in progress
//   FRAME_ERR  one-cycle pulse: frame ended with a partial word
//   OVERRUN    one-cycle pulse: word dropped because holding register full
module qspi_receiver #(
    parameter int G_WORD_SIZE   = 8,
    parameter int G_SYNC_STAGES = 2,
    parameter int G_TIMEOUT     = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SPI_CLK,
    input  logic                   CE,
    input  logic [3:0]             DQ,
    input  logic                   QUAD_MODE,
    output logic [G_WORD_SIZE-1:0] DATA_OUT,
    output logic                   DO_VALID,
    input  logic                   DO_READY,
    output logic                   RX_BUSY,
    output logic                   FRAME_ERR,
    output logic                   OVERRUN
);

    localparam int CNT_W  = $clog2(G_WORD_SIZE + 1);
    localparam int FILL_W = $clog2(G_SYNC_STAGES + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchroniser chains (index 0 = first stage)
    logic [G_SYNC_STAGES-1:0]      sclk_pipe_q, sclk_pipe_d;
    logic [G_SYNC_STAGES-1:0]      ce_pipe_q, ce_pipe_d;
    logic [G_SYNC_STAGES-1:0][3:0] dq_pipe_q, dq_pipe_d;

    // Counts stages filled since reset; the chains' reset values are not
    // real observations of the pins, so CE is not trusted until filled.
    logic [FILL_W-1:0]      sync_fill_q, sync_fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    // Last trusted CE sample was high: a frame may only start after this.
    logic                   ce_hi_q, ce_hi_d;

    state_t                 state_q, state_d;
    logic                   quad_q, quad_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [G_WORD_SIZE-1:0] shift_q, shift_d;
    logic [G_WORD_SIZE-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic                   sclk_s, ce_s;
    logic [3:0]             dq_s;
    logic                   sync_ok, sclk_rise, ce_fall, word_done;
    logic [CNT_W:0]         cnt_sum;
    logic [G_WORD_SIZE-1:0] shift_in;

`ifdef QSPI_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(G_TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_hit;
`else
    // G_TIMEOUT has no effect in this build.
    logic timeout_unused;
    assign timeout_unused = (G_TIMEOUT != 0);
`endif

    assign sclk_s    = sclk_pipe_q[G_SYNC_STAGES-1];
    assign ce_s      = ce_pipe_q[G_SYNC_STAGES-1];
    assign dq_s      = dq_pipe_q[G_SYNC_STAGES-1];
    assign sync_ok   = (sync_fill_q == FILL_W'(G_SYNC_STAGES));
    assign sclk_rise = sync_ok & sclk_s & ~sclk_prev_q;
    assign ce_fall   = sync_ok & ce_hi_q & ~ce_s;

    // Next shift value and bit count as if an edge is taken this cycle
    assign shift_in  = quad_q ? ((shift_q << 4) | G_WORD_SIZE'(dq_s))
                              : ((shift_q << 1) | G_WORD_SIZE'(dq_s[0]));
    assign cnt_sum   = {1'b0, cnt_q} + (quad_q ? (CNT_W+1)'(4) : (CNT_W+1)'(1));
    assign word_done = (cnt_sum >= (CNT_W+1)'(G_WORD_SIZE));

`ifdef QSPI_RX_TIMEOUT_EN
    assign timeout_hit = !sclk_rise && (idle_cnt_q == TO_W'(G_TIMEOUT - 1));
`endif

    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[G_SYNC_STAGES-2:0], SPI_CLK};
        ce_pipe_d   = {ce_pipe_q[G_SYNC_STAGES-2:0], CE};
        dq_pipe_d   = {dq_pipe_q[G_SYNC_STAGES-2:0], DQ};
        sync_fill_d = sync_ok ? sync_fill_q : sync_fill_q + FILL_W'(1);
        sclk_prev_d = sclk_s;
        ce_hi_d     = sync_ok & ce_s;

        state_d     = state_q;
        quad_d      = quad_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~DO_READY;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef QSPI_RX_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ce_fall) begin
                    state_d = ST_SHIFT;
                    quad_d  = QUAD_MODE;
                    cnt_d   = '0;
                    shift_d = '0;
`ifdef QSPI_RX_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end

            ST_SHIFT: begin
                // An edge in the same cycle as CE rising is taken first.
                if (sclk_rise) begin
                    shift_d = shift_in;
`ifdef QSPI_RX_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (word_done) begin
                        cnt_d = '0;
                        // A read in this same cycle frees the register.
                        if (!valid_q || DO_READY) begin
                            data_d  = shift_in;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_sum[CNT_W-1:0];
                    end
                end
`ifdef QSPI_RX_TIMEOUT_EN
                else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
`endif

                if (ce_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (cnt_d != '0);
                    cnt_d       = '0;
                    shift_d     = '0;
                end
`ifdef QSPI_RX_TIMEOUT_EN
                else if (timeout_hit) begin
                    // ce_hi_q is low here, so the next frame needs CE high then low.
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    shift_d     = '0;
                    idle_cnt_d  = '0;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclk_pipe_q <= '0;
            ce_pipe_q   <= '1;
            dq_pipe_q   <= '0;
            sync_fill_q <= '0;
            sclk_prev_q <= 1'b0;
            ce_hi_q     <= 1'b0;
            state_q     <= ST_IDLE;
            quad_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef QSPI_RX_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            sclk_pipe_q <= sclk_pipe_d;
            ce_pipe_q   <= ce_pipe_d;
            dq_pipe_q   <= dq_pipe_d;
            sync_fill_q <= sync_fill_d;
            sclk_prev_q <= sclk_prev_d;
            ce_hi_q     <= ce_hi_d;
            state_q     <= state_d;
            quad_q      <= quad_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef QSPI_RX_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign DATA_OUT  = data_q;
    assign DO_VALID  = valid_q;
    assign RX_BUSY   = (state_q == ST_SHIFT);
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_qspi_receiver.sv
`timescale 1ns/1ps
// Testbench for qspi_receiver: directed scenarios plus randomized frames,
// checked against a word-level model of the link (words MSB first, partial
// words flagged, one-word holding register).
module tb_qspi_receiver;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         spi_clk;
    logic         ce;
    logic [3:0]   dq;
    logic         quad;
    logic [W-1:0] data_out;
    logic         do_valid;
    logic         do_ready;
    logic         rx_busy;
    logic         frame_err;
    logic         overrun;

    always #5 clk = ~clk;

    qspi_receiver #(
        .G_WORD_SIZE  (W),
        .G_SYNC_STAGES(S),
        .G_TIMEOUT    (TO)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .SPI_CLK  (spi_clk),
        .CE       (ce),
        .DQ       (dq),
        .QUAD_MODE(quad),
        .DATA_OUT (data_out),
        .DO_VALID (do_valid),
        .DO_READY (do_ready),
        .RX_BUSY  (rx_busy),
        .FRAME_ERR(frame_err),
        .OVERRUN  (overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed traffic
    logic [W-1:0] rx_q[$];
    logic [W-1:0] exp_q[$];
    int fe_pulses, fe_cycles, ov_pulses;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (do_valid && do_ready) rx_q.push_back(data_out);
            if (frame_err) fe_cycles++;
            if (frame_err && !fe_prev) fe_pulses++;
            if (overrun && !ov_prev) ov_pulses++;
        end
        fe_prev = frame_err;
        ov_prev = overrun;
    end

    task automatic clear_counts();
        fe_pulses = 0;
        fe_cycles = 0;
        ov_pulses = 0;
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_nwords"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq({tag, "_word"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edge_out(input logic [3:0] v, input int half);
        dq = v;
        tick(half);
        spi_clk = 1'b1;
        tick(half);
        spi_clk = 1'b0;
    endtask

    task automatic start_frame(input logic q);
        quad = q;
        ce   = 1'b0;
        tick(4);
    endtask

    task automatic end_frame();
        tick(2);
        ce = 1'b1;
        tick(10);
    endtask

    // Serialise one word MSB first; idle lanes carry noise in single mode.
    task automatic send_word(input logic q, input logic [W-1:0] w, input int half);
        logic [3:0] noise;
        if (q) begin
            for (int k = W/4 - 1; k >= 0; k--) edge_out(w[4*k +: 4], half);
        end else begin
            for (int b = W - 1; b >= 0; b--) begin
                noise = 4'($urandom);
                edge_out({noise[3:1], w[b]}, half);
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nw, epw, part, half;
        logic q;
        logic [W-1:0] w;

        rst = 1'b1; ce = 1'b1; spi_clk = 1'b0; dq = '0; quad = 1'b0; do_ready = 1'b1;
        clear_counts();
        tick(3);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_do_valid", do_valid, 0);
        check_eq("rst_rx_busy", rx_busy, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick(5);

        // Single mode word 0x85
        clear_counts();
        start_frame(1'b0);
        exp_q.push_back(8'h85);
        send_word(1'b0, 8'h85, 2);
        check_eq("t1_busy_in_frame", rx_busy, 1);
        end_frame();
        check_rx("t1");
        check_eq("t1_frame_err", fe_pulses, 0);
        check_eq("t1_busy_after", rx_busy, 0);

        // Quad mode 0xA5 with output latency after the last edge
        clear_counts();
        start_frame(1'b1);
        edge_out(4'hA, 3);
        dq = 4'h5;
        tick(3);
        spi_clk = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!do_valid && n < 20);
        check_eq("t2_latency", n, S + 1);
        spi_clk = 1'b0;
        exp_q.push_back(8'hA5);
        end_frame();
        check_rx("t2");

        // Abort after 5 edges, then a clean 0x3C frame
        clear_counts();
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) edge_out(4'($urandom), 2);
        end_frame();
        check_eq("t3_fe_pulses", fe_pulses, 1);
        check_eq("t3_fe_width", fe_cycles, 1);
        check_rx("t3_abort");
        clear_counts();
        start_frame(1'b0);
        send_word(1'b0, 8'h3C, 3);
        exp_q.push_back(8'h3C);
        end_frame();
        check_rx("t3_next");
        check_eq("t3_next_fe", fe_pulses, 0);

        // Holding register full: second word dropped
        clear_counts();
        do_ready = 1'b0;
        start_frame(1'b0);
        send_word(1'b0, 8'h11, 2);
        send_word(1'b0, 8'h22, 2);
        end_frame();
        check_eq("t4_data_held", data_out, 8'h11);
        check_eq("t4_valid_held", do_valid, 1);
        check_eq("t4_overrun", ov_pulses, 1);
        check_eq("t4_no_accept", rx_q.size(), 0);
        do_ready = 1'b1;
        tick(1);
        check_eq("t4_valid_drop", do_valid, 0);
        tick(10);
        exp_q.push_back(8'h11);
        check_rx("t4");

        // CE rises in the same cycle as the final rising edge
        clear_counts();
        start_frame(1'b0);
        w = 8'h96;
        for (int b = W - 1; b >= 1; b--) edge_out({3'b000, w[b]}, 2);
        dq = {3'b000, w[0]};
        tick(2);
        spi_clk = 1'b1;
        ce = 1'b1;
        tick(3);
        spi_clk = 1'b0;
        tick(10);
        exp_q.push_back(8'h96);
        check_rx("t5");
        check_eq("t5_fe", fe_pulses, 0);

        // Reset in mid-frame, remaining edges ignored
        clear_counts();
        start_frame(1'b0);
        for (int i = 0; i < 4; i++) edge_out(4'h1, 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_eq("t6_data_out", data_out, 0);
        check_eq("t6_do_valid", do_valid, 0);
        check_eq("t6_rx_busy", rx_busy, 0);
        check_eq("t6_frame_err", frame_err, 0);
        check_eq("t6_overrun", overrun, 0);
        for (int i = 0; i < 4; i++) edge_out(4'h0, 2);
        check_eq("t6_busy_ignored", rx_busy, 0);
        end_frame();
        check_rx("t6");
        check_eq("t6_fe", fe_pulses, 0);

        // SPI_CLK stalls mid-frame
        clear_counts();
        start_frame(1'b0);
        for (int i = 0; i < 3; i++) edge_out(4'h1, 2);
        tick(40);
`ifdef QSPI_RX_TIMEOUT_EN
        check_eq("t7_to_fe", fe_pulses, 1);
        check_eq("t7_to_busy", rx_busy, 0);
        end_frame();
        check_eq("t7_to_fe_after_ce", fe_pulses, 1);
`else
        check_eq("t7_stall_busy", rx_busy, 1);
        end_frame();
        check_eq("t7_stall_fe", fe_pulses, 1);
        check_eq("t7_stall_busy_after", rx_busy, 0);
`endif
        check_rx("t7");

        // Randomized frames against the word-level model
        for (int f = 0; f < 12; f++) begin
            clear_counts();
            q    = 1'($urandom);
            nw   = 1 + int'($urandom % 3);
            epw  = q ? W / 4 : W;
            part = ($urandom % 3 == 0) ? 1 + int'($urandom % (epw - 1)) : 0;
            half = 2 + int'($urandom % 3);
            start_frame(q);
            quad = 1'($urandom);
            for (int k = 0; k < nw; k++) begin
                w = W'($urandom);
                exp_q.push_back(w);
                send_word(q, w, half);
            end
            for (int k = 0; k < part; k++) edge_out(4'($urandom), half);
            end_frame();
            check_rx("rnd");
            check_eq("rnd_fe", fe_pulses, (part != 0) ? 1 : 0);
            check_eq("rnd_fe_width", fe_cycles, (part != 0) ? 1 : 0);
            check_eq("rnd_overrun", ov_pulses, 0);
            check_eq("rnd_busy", rx_busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
